// File: rtl/adc_sample_fifo.sv
// ADC capture FIFO: EOC rising-edge capture into a first-word-fall-through buffer drained by the FIR stage,
// with full feedback, a one-shot level-threshold interrupt and a sticky overrun flag.
module adc_sample_fifo #(
   parameter int DATA_W     = 12,
   parameter int DEPTH      = 16,
   parameter int INT_THRESH = 8
) (
   input  logic                     clk_in,
   input  logic                     rst_in,
   input  logic                     en_in,
   input  logic                     eoc_in,
   input  logic [DATA_W-1:0]        adc_data_in,
   input  logic                     flush_in,
   input  logic                     ovr_clr_in,
   input  logic                     rd_ready_in,
   output logic                     rd_valid_out,
   output logic [DATA_W-1:0]        rd_data_out,
   output logic [$clog2(DEPTH):0]   level_out,
   output logic                     full_out,
   output logic                     int_out,
   output logic                     overrun_out
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;
   localparam logic [LW-1:0] LVL_FULL = LW'(DEPTH);
   localparam logic [LW-1:0] LVL_THR  = LW'(INT_THRESH);

   typedef enum logic {ST_BELOW, ST_ABOVE} thr_state_t;

   logic [DATA_W-1:0] mem [DEPTH];
   logic [AW-1:0]     wr_ptr;
   logic [AW-1:0]     rd_ptr;
   logic              eoc_d;
   logic              push_req;
   logic              pop;
   logic              push;
   logic              drop;
   logic [LW-1:0]     level_nxt;
   thr_state_t        state;
   thr_state_t        state_nxt;
   logic              int_nxt;

   assign rd_valid_out = (level_out != '0);
   assign full_out     = (level_out == LVL_FULL);
   // Gated so the unreset memory never leaks X onto the port while empty.
   assign rd_data_out  = rd_valid_out ? mem[rd_ptr] : '0;

   assign push_req = en_in & eoc_in & ~eoc_d;
   assign pop      = rd_valid_out & rd_ready_in & ~flush_in;
   assign push     = push_req & (~full_out | pop) & ~flush_in;
   assign drop     = push_req & full_out & ~pop & ~flush_in;

   always_comb begin
      level_nxt = level_out;
      if (flush_in)
         level_nxt = '0;
      else if (push && !pop)
         level_nxt = level_out + LW'(1);
      else if (!push && pop)
         level_nxt = level_out - LW'(1);
   end

   // Threshold tracker looks at the upcoming level so int_out lines up with level_out.
   always_comb begin
      state_nxt = state;
      int_nxt   = 1'b0;
      if (flush_in) begin
         state_nxt = ST_BELOW;
      end else begin
         case (state)
            ST_BELOW: begin
               if (level_nxt >= LVL_THR) begin
                  state_nxt = ST_ABOVE;
                  int_nxt   = 1'b1;
               end
            end
            ST_ABOVE: begin
               if (level_nxt < LVL_THR)
                  state_nxt = ST_BELOW;
            end
            default: state_nxt = ST_BELOW;
         endcase
      end
   end

   always_ff @(posedge clk_in) begin
      if (push)
         mem[wr_ptr] <= adc_data_in;
   end

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         eoc_d       <= 1'b0;
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         level_out   <= '0;
         state       <= ST_BELOW;
         int_out     <= 1'b0;
         overrun_out <= 1'b0;
      end else begin
         eoc_d     <= eoc_in;
         level_out <= level_nxt;
         state     <= state_nxt;
         int_out   <= int_nxt;
         if (flush_in) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
         end else begin
            if (push)
               wr_ptr <= wr_ptr + AW'(1);
            if (pop)
               rd_ptr <= rd_ptr + AW'(1);
         end
         if (drop)
            overrun_out <= 1'b1;
         else if (ovr_clr_in)
            overrun_out <= 1'b0;
      end
   end

endmodule

// File: tb/tb_adc_sample_fifo.sv
// Directed bench for adc_sample_fifo with a queue scoreboard tracking stored samples, level, interrupt and overrun.
module tb_adc_sample_fifo;

   localparam int DATA_W     = 12;
   localparam int DEPTH      = 16;
   localparam int INT_THRESH = 8;

   logic                   clk_in = 1'b0;
   logic                   rst_in;
   logic                   en_in;
   logic                   eoc_in;
   logic [DATA_W-1:0]      adc_data_in;
   logic                   flush_in;
   logic                   ovr_clr_in;
   logic                   rd_ready_in;
   logic                   rd_valid_out;
   logic [DATA_W-1:0]      rd_data_out;
   logic [$clog2(DEPTH):0] level_out;
   logic                   full_out;
   logic                   int_out;
   logic                   overrun_out;

   logic [DATA_W-1:0] sb[$];
   int  errors  = 0;
   int  checks  = 0;
   int  int_cnt = 0;
   bit  eoc_prev, above_m, int_m, ovr_m;

   adc_sample_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH), .INT_THRESH(INT_THRESH)) dut (
      .clk_in(clk_in), .rst_in(rst_in), .en_in(en_in), .eoc_in(eoc_in), .adc_data_in(adc_data_in),
      .flush_in(flush_in), .ovr_clr_in(ovr_clr_in), .rd_ready_in(rd_ready_in),
      .rd_valid_out(rd_valid_out), .rd_data_out(rd_data_out), .level_out(level_out),
      .full_out(full_out), .int_out(int_out), .overrun_out(overrun_out)
   );

   always #5 clk_in = ~clk_in;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Compare current outputs to the model, advance the model by one edge, then step the clock.
   task automatic cycle();
      int n;
      bit pop_m, edge_m, room;
      n = sb.size();
      check("rd_valid", 32'(n != 0), 32'(rd_valid_out));
      check("level", 32'(level_out), 32'(n));
      check("full", 32'(full_out), 32'(n == DEPTH));
      check("int", 32'(int_out), 32'(int_m));
      check("overrun", 32'(overrun_out), 32'(ovr_m));
      check("rd_data", 32'(rd_data_out), (n != 0) ? 32'(sb[0]) : 32'd0);
      if (int_out) int_cnt++;
      pop_m  = (n != 0) && rd_ready_in;
      edge_m = en_in && eoc_in && !eoc_prev;
      room   = (n < DEPTH) || pop_m;
      eoc_prev = eoc_in;
      if (flush_in) begin
         sb.delete();
         above_m = 1'b0;
         int_m   = 1'b0;
         if (ovr_clr_in) ovr_m = 1'b0;
      end else begin
         if (pop_m) check("pop_data", 32'(rd_data_out), 32'(sb.pop_front()));
         if (edge_m && room) sb.push_back(adc_data_in);
         if (edge_m && !room) ovr_m = 1'b1;
         else if (ovr_clr_in) ovr_m = 1'b0;
         int_m = 1'b0;
         if (!above_m && sb.size() >= INT_THRESH) begin
            above_m = 1'b1;
            int_m   = 1'b1;
         end else if (sb.size() < INT_THRESH) begin
            above_m = 1'b0;
         end
      end
      @(posedge clk_in);
      #1;
   endtask

   task automatic pulse(input logic [DATA_W-1:0] d);
      eoc_in      = 1'b1;
      adc_data_in = d;
      cycle();
      eoc_in = 1'b0;
      cycle();
   endtask

   initial begin
      rst_in = 1'b1; en_in = 1'b0; eoc_in = 1'b0; adc_data_in = '0;
      flush_in = 1'b0; ovr_clr_in = 1'b0; rd_ready_in = 1'b0;
      repeat (2) @(posedge clk_in);
      #1;
      check("rst_valid", 32'(rd_valid_out), 32'd0);
      check("rst_data", 32'(rd_data_out), 32'd0);
      check("rst_level", 32'(level_out), 32'd0);
      check("rst_full", 32'(full_out), 32'd0);
      check("rst_int", 32'(int_out), 32'd0);
      check("rst_ovr", 32'(overrun_out), 32'd0);
      rst_in = 1'b0;

      // 1: three captures, then in-order reads
      en_in = 1'b1;
      pulse(12'h101); pulse(12'h202); pulse(12'h303);
      check("t1_level", 32'(level_out), 32'd3);
      check("t1_head", 32'(rd_data_out), 32'h101);
      rd_ready_in = 1'b1;
      repeat (3) cycle();
      rd_ready_in = 1'b0;
      check("t1_empty", 32'(rd_valid_out), 32'd0);

      // 2: held EOC gives one push; disabled capture ignores edges
      eoc_in = 1'b1; adc_data_in = 12'h2AA;
      repeat (10) cycle();
      eoc_in = 1'b0;
      cycle();
      check("t2_held", 32'(level_out), 32'd1);
      en_in = 1'b0;
      pulse(12'h2B1); pulse(12'h2B2); pulse(12'h2B3);
      check("t2_disabled", 32'(level_out), 32'd1);
      en_in = 1'b1;
      rd_ready_in = 1'b1; cycle(); rd_ready_in = 1'b0;

      // 3: fill, overflow drop, overrun clear
      for (int i = 0; i < DEPTH; i++) pulse(12'h500 + 12'(i));
      check("t3_full", 32'(full_out), 32'd1);
      pulse(12'h0EE);
      check("t3_ovr", 32'(overrun_out), 32'd1);
      check("t3_level", 32'(level_out), 32'd16);
      check("t3_head", 32'(rd_data_out), 32'h500);
      ovr_clr_in = 1'b1; cycle(); ovr_clr_in = 1'b0;
      check("t3_ovr_clr", 32'(overrun_out), 32'd0);

      // 4: push into a full FIFO while popping
      eoc_in = 1'b1; adc_data_in = 12'h444; rd_ready_in = 1'b1;
      cycle();
      eoc_in = 1'b0; rd_ready_in = 1'b0;
      cycle();
      check("t4_level", 32'(level_out), 32'd16);
      check("t4_ovr", 32'(overrun_out), 32'd0);
      check("t4_head", 32'(rd_data_out), 32'h501);
      flush_in = 1'b1; cycle(); flush_in = 1'b0;
      check("t4_flush", 32'(level_out), 32'd0);

      // 5: threshold interrupt
      int_cnt = 0;
      for (int i = 0; i < INT_THRESH - 1; i++) pulse(12'h600 + 12'(i));
      check("t5_below", 32'(int_cnt), 32'd0);
      pulse(12'h607);
      check("t5_first", 32'(int_cnt), 32'd1);
      rd_ready_in = 1'b1; cycle(); rd_ready_in = 1'b0;
      cycle();
      pulse(12'h608);
      check("t5_second", 32'(int_cnt), 32'd2);
      pulse(12'h609); pulse(12'h60A);
      check("t5_no_repulse", 32'(int_cnt), 32'd2);
      flush_in = 1'b1; cycle(); flush_in = 1'b0;

      // 6: flush beats a simultaneous push, then wrap with streaming reads
      for (int i = 0; i < 5; i++) pulse(12'h680 + 12'(i));
      check("t6_level5", 32'(level_out), 32'd5);
      int_cnt = 0;
      flush_in = 1'b1; eoc_in = 1'b1; adc_data_in = 12'h666;
      cycle();
      flush_in = 1'b0; eoc_in = 1'b0;
      check("t6_level0", 32'(level_out), 32'd0);
      check("t6_valid0", 32'(rd_valid_out), 32'd0);
      check("t6_no_int", 32'(int_out), 32'd0);
      cycle();
      rd_ready_in = 1'b1;
      for (int i = 0; i < 20; i++) pulse(12'h700 + 12'(i));
      rd_ready_in = 1'b0;
      cycle();
      check("t6_drained", 32'(level_out), 32'd0);
      check("t6_int_cnt", 32'(int_cnt), 32'd0);

      // 7: asynchronous reset mid-operation
      pulse(12'h911); pulse(12'h922); pulse(12'h933);
      #2;
      rst_in = 1'b1;
      #1;
      check("t7_async_level", 32'(level_out), 32'd0);
      check("t7_async_valid", 32'(rd_valid_out), 32'd0);
      @(posedge clk_in);
      #1;
      rst_in = 1'b0;
      sb.delete();
      eoc_prev = 1'b0; above_m = 1'b0; int_m = 1'b0; ovr_m = 1'b0;
      pulse(12'hA5A);
      check("t7_head", 32'(rd_data_out), 32'hA5A);
      rd_ready_in = 1'b1; cycle(); rd_ready_in = 1'b0;
      cycle();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
